// File: rtl/piece_bag_queue_pkg.sv
// piece_bag_queue_pkg: shared piece codes, widths and bag-mask helpers.
package piece_bag_queue_pkg;
  localparam int PIECE_W = 3;
  localparam int NUM_PIECES = 7;
  localparam int REJ_LIMIT_DEF = 8;
  typedef logic [PIECE_W-1:0] piece_t;
  typedef logic [NUM_PIECES-1:0] mask_t;
  localparam piece_t PIECE_NONE = 3'd0;
  localparam piece_t PIECE_I = 3'd1;
  localparam piece_t PIECE_O = 3'd2;
  localparam piece_t PIECE_T = 3'd3;
  localparam piece_t PIECE_S = 3'd4;
  localparam piece_t PIECE_Z = 3'd5;
  localparam piece_t PIECE_J = 3'd6;
  localparam piece_t PIECE_L = 3'd7;
  typedef enum logic {ST_FILL, ST_HOLD} state_t;
  function automatic mask_t piece_bit(input piece_t p);
    return (p == PIECE_NONE) ? '0 : mask_t'(1) << (p - piece_t'(1));
  endfunction
  function automatic piece_t first_free(input mask_t m);
    piece_t r;
    r = PIECE_NONE;
    for (int k = NUM_PIECES - 1; k >= 0; k--) if (!m[k]) r = piece_t'(k + 1);
    return r;
  endfunction
endpackage

// File: rtl/piece_bag_queue_if.sv
// piece_bag_queue_if: generator/controller-facing signals of the piece bag queue.
interface piece_bag_queue_if #(parameter int QDEPTH = 4);
  import piece_bag_queue_pkg::*;
  localparam int CW = $clog2(QDEPTH + 1);
  piece_t rnd_in;
  logic pop;
  piece_t piece_out;
  logic piece_valid;
  logic [PIECE_W*(QDEPTH-1)-1:0] preview;
  logic [CW-1:0] count;
  logic bag_done;
  modport master (output rnd_in, pop, input piece_out, piece_valid, preview, count, bag_done);
  modport slave (input rnd_in, pop, output piece_out, piece_valid, preview, count, bag_done);
endinterface

// File: rtl/piece_bag_queue_shift_queue.sv
// piece_shift_queue: QDEPTH-entry shift queue, head at entry 0, packed preview of the rest.
module piece_shift_queue
  import piece_bag_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int W = PIECE_W,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            din_i,
  output logic [W-1:0]            head_o,
  output logic [W*(QDEPTH-1)-1:0] preview_o,
  output logic [CW-1:0]           count_o,
  output logic                    valid_o
);
  logic [W-1:0] q_q [QDEPTH];
  logic [W-1:0] q_d [QDEPTH];
  logic [CW-1:0] cnt_q, cnt_d, cnt_s;
  logic pop_v;
  always_comb begin
    pop_v = pop_i && cnt_q != '0;
    cnt_s = pop_v ? cnt_q - 1'b1 : cnt_q;
    for (int i = 0; i < QDEPTH - 1; i++) q_d[i] = pop_v ? q_q[i+1] : q_q[i];
    q_d[QDEPTH-1] = pop_v ? '0 : q_q[QDEPTH-1];
    // the new piece lands just above the post-shift tail
    for (int i = 0; i < QDEPTH; i++) if (push_i && cnt_s == CW'(i)) q_d[i] = din_i;
    cnt_d = cnt_s + CW'(push_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      q_q <= q_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_o = q_q[0];
  assign count_o = cnt_q;
  assign valid_o = cnt_q != '0;
  for (genvar g = 1; g < QDEPTH; g++) begin : g_prev
    assign preview_o[W*(g-1) +: W] = q_q[g];
  end
endmodule

// File: rtl/piece_bag_queue.sv
// piece_bag_queue: 7-bag piece randomiser with rejection, forced pick and preview queue.
module piece_bag_queue
  import piece_bag_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int REJ_LIMIT = REJ_LIMIT_DEF
) (
  input logic clk,
  input logic rst,
  piece_bag_queue_if.slave bus
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int RW = $clog2(REJ_LIMIT);
  state_t st_q, st_d;
  mask_t mask_q, mask_d, mask_nx;
  logic [RW-1:0] rej_q, rej_d;
  logic bag_done_q, bag_done_d;
  logic [CW-1:0] cnt;
  logic pop_v, push_en, accept, force_pick, push;
  piece_t din;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_FILL;
      mask_q <= '0;
      rej_q <= '0;
      bag_done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      mask_q <= mask_d;
      rej_q <= rej_d;
      bag_done_q <= bag_done_d;
    end
  end
  always_comb begin
    st_d = (cnt - CW'(pop_v) + CW'(push) == CW'(QDEPTH)) ? ST_HOLD : ST_FILL;
  end
  always_comb begin
    pop_v = bus.pop && cnt != '0;
    push_en = st_q == ST_FILL || pop_v;
    accept = bus.rnd_in != PIECE_NONE && (mask_q & piece_bit(bus.rnd_in)) == '0;
    // the rejection that would reach REJ_LIMIT becomes a forced pick instead
    force_pick = !accept && rej_q == RW'(REJ_LIMIT - 1);
    push = push_en && (accept || force_pick);
    din = accept ? bus.rnd_in : first_free(mask_q);
    mask_nx = mask_q | piece_bit(din);
    bag_done_d = push && &mask_nx;
    mask_d = !push ? mask_q : bag_done_d ? '0 : mask_nx;
    rej_d = !push_en ? rej_q : push ? '0 : rej_q + 1'b1;
  end
  piece_shift_queue #(.QDEPTH(QDEPTH), .W(PIECE_W)) u_q (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop_v),
    .din_i     (din),
    .head_o    (bus.piece_out),
    .preview_o (bus.preview),
    .count_o   (cnt),
    .valid_o   (bus.piece_valid)
  );
  assign bus.count = cnt;
  assign bus.bag_done = bag_done_q;
endmodule

// File: tb/tb_piece_bag_queue.sv
// tb_piece_bag_queue: directed steps checked against a queue scoreboard of predicted pieces.
module tb_piece_bag_queue;
  import piece_bag_queue_pkg::*;
  localparam int QD = 4;
  localparam int RL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int q_m[$];
  logic [6:0] mask_m = '0;
  int rej_m = 0;
  always #5 clk = ~clk;
  piece_bag_queue_if #(.QDEPTH(QD)) bus();
  piece_bag_queue #(.QDEPTH(QD), .REJ_LIMIT(RL)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic check_outputs(input logic exp_bd);
    logic [8:0] pv_e;
    pv_e = '0;
    for (int i = 1; i < q_m.size(); i++) pv_e[3*(i-1) +: 3] = 3'(q_m[i]);
    chk("count", 32'(bus.count), 32'(q_m.size()));
    chk("piece_valid", 32'(bus.piece_valid), 32'(q_m.size() != 0));
    chk("piece_out", 32'(bus.piece_out), 32'(q_m.size() != 0 ? q_m[0] : 0));
    chk("preview", 32'(bus.preview), 32'(pv_e));
    chk("bag_done", 32'(bus.bag_done), 32'(exp_bd));
  endtask
  task automatic step(input logic [2:0] r, input logic p);
    logic pv, fill, bd;
    logic [2:0] d;
    logic [6:0] nx;
    int old;
    bus.rnd_in = r;
    bus.pop = p;
    pv = p && q_m.size() != 0;
    fill = q_m.size() < QD || pv;
    d = '0;
    bd = 1'b0;
    if (pv) begin
      old = q_m.pop_front();
      chk("pop_head", 32'(bus.piece_out), 32'(old));
    end
    if (fill) begin
      if (r != 3'd0 && !mask_m[r - 3'd1]) d = r;
      else if (rej_m == RL - 1) for (int k = 7; k >= 1; k--) if (!mask_m[k-1]) d = 3'(k);
      if (d != 3'd0) begin
        q_m.push_back(int'(d));
        rej_m = 0;
        nx = mask_m | (7'd1 << (d - 3'd1));
        bd = nx == 7'h7F;
        mask_m = bd ? '0 : nx;
      end else rej_m++;
    end
    @(posedge clk);
    #1;
    check_outputs(bd);
  endtask
  task automatic do_reset(input logic p);
    bus.pop = p;
    bus.rnd_in = 3'd1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_m.delete();
    mask_m = '0;
    rej_m = 0;
    check_outputs(1'b0);
  endtask
  initial begin
    bus.rnd_in = 3'd0;
    bus.pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    step(3'd1, 1'b0);
    chk("first_valid", 32'(bus.piece_valid), 32'd1);
    step(3'd2, 1'b0);
    step(3'd3, 1'b0);
    step(3'd4, 1'b0);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_head", 32'(bus.piece_out), 32'd1);
    chk("fill_preview", 32'(bus.preview), 32'({3'd4, 3'd3, 3'd2}));
    repeat (3) step(3'd5, 1'b0);
    chk("hold_count", 32'(bus.count), 32'd4);
    chk("hold_preview", 32'(bus.preview), 32'({3'd4, 3'd3, 3'd2}));
    step(3'd5, 1'b1);
    chk("pp_head", 32'(bus.piece_out), 32'd2);
    chk("pp_preview", 32'(bus.preview), 32'({3'd5, 3'd4, 3'd3}));
    chk("pp_count", 32'(bus.count), 32'd4);
    repeat (6) step(3'd0, 1'b1);
    chk("drain_count", 32'(bus.count), 32'd0);
    do_reset(1'b0);
    step(3'd5, 1'b0);
    step(3'd5, 1'b0);
    step(3'd0, 1'b0);
    step(3'd6, 1'b0);
    chk("dup_head", 32'(bus.piece_out), 32'd5);
    chk("dup_count", 32'(bus.count), 32'd2);
    chk("dup_preview", 32'(bus.preview), 32'd6);
    do_reset(1'b0);
    step(3'd1, 1'b0);
    step(3'd2, 1'b0);
    step(3'd3, 1'b0);
    repeat (7) step(3'd3, 1'b0);
    chk("force_wait", 32'(bus.count), 32'd3);
    step(3'd3, 1'b0);
    chk("force_count", 32'(bus.count), 32'd4);
    chk("force_code", 32'(bus.preview[8:6]), 32'd4);
    step(3'd3, 1'b1);
    repeat (6) step(3'd3, 1'b0);
    chk("rej_restart", 32'(bus.count), 32'd3);
    step(3'd3, 1'b0);
    chk("force2_code", 32'(bus.preview[8:6]), 32'd5);
    do_reset(1'b1);
    for (int v = 7; v >= 1; v--) step(3'(v), 1'b1);
    chk("wrap_done", 32'(bus.bag_done), 32'd1);
    chk("wrap_head", 32'(bus.piece_out), 32'd1);
    step(3'd7, 1'b1);
    chk("wrap_again", 32'(bus.piece_out), 32'd7);
    chk("wrap_pulse", 32'(bus.bag_done), 32'd0);
    do_reset(1'b0);
    step(3'd1, 1'b0);
    step(3'd2, 1'b0);
    step(3'd3, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    do_reset(1'b1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_head", 32'(bus.piece_out), 32'd0);
    chk("rst_preview", 32'(bus.preview), 32'd0);
    step(3'd1, 1'b0);
    chk("rst_reuse", 32'(bus.piece_out), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piece_bag_queue.md
# piece_bag_queue

Consumes the 3-bit pseudo-random stream (values 1..7, one new value per clock) from the game's random generator. Turns it into a fair "7-bag" piece sequence: each piece code 1..7 appears exactly once per bag of 7. Buffers the result in a short preview queue that the game controller pops one piece at a time. Sits directly downstream of the random generator and upstream of the playfield/spawn logic.

## Interface
- QDEPTH, 4: queue entries; entry 0 is the current piece, entries 1..QDEPTH-1 are the preview.
- REJ_LIMIT, 8: consecutive rejected samples after which a deterministic pick is forced.
- clk  in  1: single clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- rnd_in  in  3: random piece code from the generator; legal values 1..7, sampled every cycle.
- pop  in  1: controller consumes the current piece; ignored when piece_valid=0.
- piece_out  out  3: current piece (queue entry 0); 0 when empty.
- piece_valid  out  1: queue holds at least one entry.
- preview  out  3*(QDEPTH-1): entries 1..QDEPTH-1, with entry 1 at bits [2:0]; unused slots read 0.
- count  out  $clog2(QDEPTH+1): number of valid entries.
- bag_done  out  1: one-cycle pulse on the cycle the 7th piece of a bag is pushed.

## Operation
- State: queue registers, count, 7-bit used mask (bit k = code k+1 already drawn this bag), reject counter rej_cnt (width $clog2(REJ_LIMIT)).
- FSM, derived from count:
  - FILL: count<QDEPTH, or count==QDEPTH with pop in the same cycle. A push is attempted this cycle.
  - HOLD: count==QDEPTH and no pop. No push; rnd_in is ignored; rej_cnt holds.
- Push attempt, per cycle in FILL:
  - Accept rnd_in if it is 1..7 and its mask bit is clear.
  - Reject otherwise, including rnd_in=0 and duplicates. On reject, rej_cnt increments.
  - If a reject would bring rej_cnt to REJ_LIMIT, instead push the lowest-numbered unused code (forced pick).
  - Any push clears rej_cnt.
- Mask update on push: mask_next = mask | bit. If mask_next==7'h7F, mask becomes 0 in that same update and bag_done pulses. There is no dead cycle between bags.
- Pop (pop & piece_valid): the queue shifts down one entry and the vacated top slot becomes 0.
  - Pop with push: shift, then write the new piece at index count-1.
  - Pop without push: count decrements.
  - Push without pop: write at index count.
- Pop while empty is ignored; no state changes.
- Reset (asserted at any time, including mid-bag or mid-pop) has priority over all other activity. It sets:
  - queue=0, count=0, mask=0, rej_cnt=0
  - piece_out=0, piece_valid=0, preview=0, bag_done=0

## Timing
- All outputs are registered. An accepted or forced push is visible on piece_out/preview/count the next cycle.
- The first piece is valid on the first cycle after rst deasserts, provided the first sample is accepted.
- Pop takes effect at the clock edge. The next piece appears on piece_out the following cycle. pop held high consumes one piece per cycle.
- Worst-case fill latency per piece is REJ_LIMIT cycles, guaranteed by the forced pick.
- bag_done is high for exactly the cycle after the 7th push edge, aligned with that push's visible update.

## Structure
- The shared package holds:
  - PIECE_W=3, NUM_PIECES=7
  - piece code constants (1..7: I, O, T, S, Z, J, L)
  - PIECE_NONE=0
  - default REJ_LIMIT
- Sub-module piece_shift_queue: parameterised QDEPTH×PIECE_W shift queue with push/pop/count and packed preview output.
- The top level holds the bag mask, rejection and forced-pick logic, and the FSM.

## Test plan
- **Basic fill:** after reset, rnd_in=1,2,3,4 on consecutive cycles with no pop. Expect count=4, piece_out=1, preview={4,3,2} (bits [2:0]=2), and the queue held in HOLD.
- **Duplicate and invalid reject:** rnd_in=5,5,0,6 with the queue empty. Expect only 5 and 6 queued, piece_out=5, count=2.
- **Forced pick:** codes 1,2,3 accepted, then rnd_in held at 3, REJ_LIMIT=8. On the 8th rejected cycle, expect code 4 pushed and rej_cnt returned to 0.
- **Bag wrap:** QDEPTH=4 with pop held high, feed 7,6,5,4,3,2,1. Expect bag_done on the 7th push, mask cleared, then rnd_in=7 accepted again on the next cycle.
- **Simultaneous pop and push when full:** queue full with {1,2,3,4}, pop=1 and rnd_in=5 (unused). Next cycle expect piece_out=2, preview={5,4,3}, count=4.
- **Reset mid-operation:** rst asserted with count=3 and pop=1. Next cycle expect count=0, piece_valid=0, piece_out=0, preview=0. A previously used code is accepted again after release.
